// File: rtl/rf_dump_pkg.sv
// rtl/rf_dump_pkg.sv - shared types and constants for the register-file dump block
package rf_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2,
    ST_DONE = 2'd3
  } rf_state_e;

  localparam int RF_NREG  = 16;
  localparam int RF_W     = 16;
  localparam int RF_IDX_W = $clog2(RF_NREG);

  localparam logic [RF_W-1:0] RF_CSUM_SEED = '0;

endpackage

// File: rtl/rf_dump_penc.sv
// rtl/rf_dump_penc.sv - lowest-set-bit priority encoder over the pending register mask
module rf_dump_penc #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan downward so the lowest set bit is the final (winning) assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/rf_dump.sv
// rtl/rf_dump.sv - register-file snapshot transmitter; optional XOR checksum beat with RF_DUMP_CSUM_EN
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int W    = RF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NREG-1:0]         reg_mask,
  input  logic [NREG*W-1:0]       regdata,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(NREG)-1:0] out_idx,
  output logic                    out_last,
  output logic                    out_csum,
  output logic                    done
);

  localparam int IW = $clog2(NREG);

  rf_state_e       state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic [W-1:0]    shadow_q [NREG];
  logic [IW-1:0]   lsb_idx;
  logic            lsb_any;
  logic [NREG-1:0] mask_clr;
  logic            fire;
  logic            capture;

  rf_dump_penc #(.N(NREG), .IW(IW)) u_penc (
    .mask_i (mask_q),
    .idx_o  (lsb_idx),
    .any_o  (lsb_any)
  );

  assign mask_clr = mask_q & (mask_q - NREG'(1));
  assign fire     = out_valid && out_ready;
  assign capture  = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Shadow copy isolates the dump from register writes after the start cycle.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NREG; i++) shadow_q[i] <= regdata[i*W +: W];
    end
  end

`ifdef RF_DUMP_CSUM_EN
  logic [W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rst)                               csum_q <= W'(RF_CSUM_SEED);
    else if (capture)                       csum_q <= W'(RF_CSUM_SEED);
    else if ((state_q == ST_SEND) && fire)  csum_q <= csum_q ^ shadow_q[lsb_idx];
  end
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = reg_mask;
          state_d = (reg_mask != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (fire) begin
          mask_d = mask_clr;
`ifdef RF_DUMP_CSUM_EN
          if (mask_clr == '0) state_d = ST_CSUM;
`else
          if (mask_clr == '0) state_d = ST_DONE;
`endif
        end
      end
`ifdef RF_DUMP_CSUM_EN
      ST_CSUM: begin
        if (fire) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_csum  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_SEND: begin
        busy      = 1'b1;
        out_valid = lsb_any;
        out_data  = shadow_q[lsb_idx];
        out_idx   = lsb_idx;
`ifdef RF_DUMP_CSUM_EN
        out_last  = 1'b0;
`else
        out_last  = (mask_clr == '0);
`endif
      end
`ifdef RF_DUMP_CSUM_EN
      ST_CSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = csum_q;
        out_csum  = 1'b1;
        out_last  = 1'b1;
      end
`endif
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rf_dump.md
# rf_dump

Register-file snapshot transmitter: on request, captures the register file's flat 256-bit `regdata` view in one cycle and streams the selected registers out one 16-bit word per beat over a valid/ready interface. It is the read-side counterpart to the register-file write port. It sits beside the register file in the 4-stage CPU and feeds the debug/trace path, so register contents can be dumped without stalling writeback.

## Interface
Parameters:
- `NREG`, 16, number of registers in the snapshot.
- `W`, 16, register width in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  dump request; sampled only in IDLE.
- `reg_mask`  in  NREG  registers to send (bit i = register i); captured with the snapshot.
- `regdata`  in  NREG*W  flat register view; register i at bits [i*W +: W].
- `busy`  out  1  high from the snapshot cycle through the DONE cycle.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  sink accepts the beat.
- `out_data`  out  W  register value.
- `out_idx`  out  log2(NREG)  register index of the beat.
- `out_last`  out  1  final beat of the dump.
- `out_csum`  out  1  beat carries the checksum (tied 0 without `RF_DUMP_CSUM_EN`).
- `done`  out  1  one-cycle pulse after the dump completes.

## Operation
- States: IDLE, SEND, CSUM (macro only), DONE.
- IDLE, `start`=1: copy `regdata` into the shadow array and `reg_mask` into the pending mask.
  - Pending mask nonzero: go to SEND.
  - Pending mask zero: go directly to DONE. No beats are sent.
- SEND:
  - `out_idx` = lowest set bit of the pending mask; `out_data` = shadow[`out_idx`].
  - `out_last`=1 when exactly one pending bit remains (and checksum is disabled).
  - On `out_valid && out_ready`: clear that bit. When the mask becomes empty, go to CSUM if enabled, otherwise DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` is ignored while busy. It is not queued.
- The shadow array decouples the dump from later register writes; the values sent are those present in the `start` cycle.
- Reset (any state, including mid-dump): all outputs return to 0, state returns to IDLE, pending mask clears. No `done` pulse is produced for an aborted dump.

## Timing
- `start` high in cycle N: `busy` and `out_valid` are high in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: while `out_valid && !out_ready`, the outputs `out_data`, `out_idx`, `out_last` and `out_csum` hold stable.
- `out_valid` never drops without a handshake.
- Last handshake in cycle M: `done`=1 in cycle M+1 (without checksum); `busy` falls in cycle M+2.
- Empty mask: `done`=1 in cycle N+1 and `out_valid` stays 0.
- Reset values: `busy`, `out_valid`, `out_data`, `out_idx`, `out_last`, `out_csum`, `done` are all 0.

## Configuration
- `RF_DUMP_CSUM_EN` defined:
  - A W-bit XOR accumulator folds in every accepted register beat.
  - After the last register, CSUM state sends one extra beat: `out_data` = XOR, `out_idx`=0, `out_csum`=1, `out_last`=1. Register beats carry `out_last`=0.
  - An empty mask still skips straight to DONE, with no checksum beat.
- `RF_DUMP_CSUM_EN` undefined: no accumulator, no CSUM state, and `out_csum` is constant 0.

## Structure
- Package `rf_dump_pkg` holds:
  - the state enum;
  - `RF_NREG`, `RF_W`, `RF_IDX_W`;
  - the checksum seed constant (0).
- One sub-module, `rf_dump_penc`: a combinational lowest-set-bit priority encoder (NREG-bit mask in; index and `any` flag out).

## Test plan
- Register i = 16'h1000+i, mask 16'hFFFF, `out_ready`=1: 16 consecutive beats with idx 0..15 and data 16'h1000..16'h100F. `out_last` on idx 15; `done` one cycle after that; 18 cycles total from `start`.
- Mask 16'h8421, `out_ready` toggled 1/0 each cycle: beats in idx order 0, 5, 10, 15. Data holds stable during stalls. `out_last` only on idx 15.
- Mask 16'h0000: `done` pulses in cycle N+1, `out_valid` never rises.
- `start` pulsed mid-dump, and `regdata` changed after the snapshot: neither the restart is seen nor the new values appear; the original snapshot is sent.
- `rst`=0 asserted after the third beat of a full dump: all outputs are 0 the next cycle with no `done`; a fresh `start` then dumps from idx 0.
- With `RF_DUMP_CSUM_EN`: registers 1=16'h00FF and 2=16'h0F0F, mask 16'h0006. Three beats: 16'h00FF, then 16'h0F0F, then checksum 16'h0FF0 with `out_csum`=1 and `out_last`=1.
